dmac_sched: RTL

DMAC_SCHED -- requirements
Module: dmac_sched

---
 rtl/dmac_pkg.sv | 20 ++
 rtl/dmac_rr_arb.sv | 35 +++
 rtl/dmac_sched.sv | 133 +++++++++++++
 3 files changed

// File: rtl/dmac_pkg.sv
// Shared types for the DMA channel scheduler: FSM states, descriptor payload
// and address width.
package dmac_pkg;

    localparam int unsigned DMAC_ADDR_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        CMPL  = 2'd3
    } dmac_state_t;

    typedef struct packed {
        logic [DMAC_ADDR_W-1:0] src;
        logic [DMAC_ADDR_W-1:0] dst;
        logic [DMAC_ADDR_W-1:0] len;
    } dmac_desc_t;

endpackage

// File: rtl/dmac_rr_arb.sv
// Combinational round-robin picker.
//   req     : request vector, one bit per requester
//   rr_ptr  : highest-priority index for this arbitration
//   grant   : index of the first requesting bit at or after rr_ptr (wrapping)
//   any_req : at least one request present (grant is only meaningful then)
module dmac_rr_arb #(
    parameter  int unsigned NUM_REQ = 4,
    localparam int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    rr_ptr,
    output logic [ID_W-1:0]    grant,
    output logic               any_req
);

    logic [ID_W-1:0] idx;
    logic            found;

    assign any_req = |req;

    // Scan from rr_ptr upward, wrapping modulo NUM_REQ; first hit wins.
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = ID_W'((32'(rr_ptr) + k) % NUM_REQ);
            if (!found && req[idx]) begin
                found = 1'b1;
                grant = idx;
            end
        end
    end

endmodule

// File: rtl/dmac_sched.sv
// Schedules descriptors from NUM_REQ requesters onto a single DMA engine.
//   ap_clk, ap_rst          : clock, synchronous active-high reset
//   req_valid/req_ready     : per-requester descriptor handshake (ready is
//                             combinational, asserted in the grant cycle)
//   req_src/req_dst/req_len : packed per-requester descriptors, 32 bits each
//   cmpl_valid, cmpl_err    : one-hot completion pulse, err = timeout
//   eng_*                   : registered descriptor, start pulse, done/idle
//   busy, grant_id          : FSM not idle, current/last granted requester
//   xfer_count              : wrapping count of completed transfers
module dmac_sched
    import dmac_pkg::*;
#(
    parameter  int unsigned NUM_REQ     = 4,
    parameter  int unsigned TIMEOUT_CYC = 65535,
    localparam int unsigned ID_W        = $clog2(NUM_REQ)
) (
    input  logic                           ap_clk,
    input  logic                           ap_rst,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ*DMAC_ADDR_W-1:0] req_src,
    input  logic [NUM_REQ*DMAC_ADDR_W-1:0] req_dst,
    input  logic [NUM_REQ*DMAC_ADDR_W-1:0] req_len,
    output logic [NUM_REQ-1:0]             cmpl_valid,
    output logic                           cmpl_err,
    output logic [DMAC_ADDR_W-1:0]         eng_src_addr,
    output logic [DMAC_ADDR_W-1:0]         eng_dst_addr,
    output logic [DMAC_ADDR_W-1:0]         eng_byte_len,
    output logic                           eng_start,
    input  logic                           eng_done,
    input  logic                           eng_idle,
    output logic                           busy,
    output logic [ID_W-1:0]                grant_id,
    output logic [31:0]                    xfer_count
);

    localparam int unsigned DW = DMAC_ADDR_W;

    dmac_state_t     state_q, state_d;
    logic [ID_W-1:0] rr_ptr_q;
    logic [ID_W-1:0] win;
    logic [ID_W-1:0] cmpl_id;
    logic            any_req;
    logic            grant_fire;
    logic            err_d;
    logic [31:0]     timer_q;
    dmac_desc_t      sel_desc;

    dmac_rr_arb #(.NUM_REQ(NUM_REQ)) u_arb (
        .req     (req_valid),
        .rr_ptr  (rr_ptr_q),
        .grant   (win),
        .any_req (any_req)
    );

    // Descriptor of the arbitration winner.
    assign sel_desc = '{src: req_src[win*DW +: DW],
                        dst: req_dst[win*DW +: DW],
                        len: req_len[win*DW +: DW]};

    // A zero-length grant goes straight to CMPL, so its id comes from the winner.
    assign cmpl_id = grant_fire ? win : grant_id;

    // Next-state and grant handshake.
    always_comb begin
        state_d    = state_q;
        req_ready  = '0;
        grant_fire = 1'b0;
        err_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (!ap_rst && any_req && eng_idle) begin
                    grant_fire     = 1'b1;
                    req_ready[win] = 1'b1;
                    state_d        = (sel_desc.len == '0) ? CMPL : START;
                end
            end
            START: state_d = WAIT;
            WAIT: begin
                // Done has priority over a coincident timeout.
                if (eng_done) begin
                    state_d = CMPL;
                end else if (timer_q == TIMEOUT_CYC) begin
                    state_d = CMPL;
                    err_d   = 1'b1;
                end
            end
            CMPL:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, datapath and registered outputs.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q      <= IDLE;
            busy         <= 1'b0;
            eng_start    <= 1'b0;
            cmpl_valid   <= '0;
            cmpl_err     <= 1'b0;
            eng_src_addr <= '0;
            eng_dst_addr <= '0;
            eng_byte_len <= '0;
            grant_id     <= '0;
            rr_ptr_q     <= '0;
            xfer_count   <= '0;
            timer_q      <= '0;
        end else begin
            state_q    <= state_d;
            busy       <= (state_d != IDLE);
            eng_start  <= (state_d == START);
            cmpl_valid <= (state_d == CMPL) ? (NUM_REQ'(1) << cmpl_id) : '0;
            cmpl_err   <= (state_d == CMPL) && err_d;

            // Timer counts cycles since START: equals k in the k-th WAIT cycle.
            if (grant_fire) begin
                eng_src_addr <= sel_desc.src;
                eng_dst_addr <= sel_desc.dst;
                eng_byte_len <= sel_desc.len;
                grant_id     <= win;
                timer_q      <= '0;
            end else if (state_q == START || state_q == WAIT) begin
                timer_q <= timer_q + 32'd1;
            end

            if (state_q == CMPL) begin
                xfer_count <= xfer_count + 32'd1;
                rr_ptr_q   <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);
            end
        end
    end

endmodule
